// File: rtl/spislave_if.sv
// AXI-Stream sample channel feeding the SPI slave transmitter.
interface spislave_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    axis_slave_valid;
  logic                    axis_slave_ready;
  logic [SAMPLE_WIDTH-1:0] axis_slave_data;

  modport master (
    output axis_slave_valid,
    output axis_slave_data,
    input  axis_slave_ready
  );

  modport slave (
    input  axis_slave_valid,
    input  axis_slave_data,
    output axis_slave_ready
  );
endinterface

// File: rtl/spislave.sv
// SPI slave transmitter (MISO only): one buffered AXIS sample is shifted out
// MSB-first per chip-select frame; clock idles high, master samples on rise.
module spislave #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             spi_clock,
  input  logic             spi_chipselect,
  output logic             spi_data,
  output logic             spi_data_enable,
  spislave_if.slave        axis,
  output logic             frame_done,
  output logic             underrun,
  output logic             aborted
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync;
  logic                    sclk_hist, cs_hist;
  logic                    sclk_rise, cs_rise, cs_fall;

  logic                    buf_full_q, buf_full_d;
  logic [SAMPLE_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [SAMPLE_WIDTH-1:0] last_sample_q, last_sample_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d, load_value;
  logic [CW-1:0]           count_q, count_d;
  logic                    ready_q;
  logic                    load, do_shift, xfer;
  logic                    spi_data_d, enable_d, done_d, underrun_d, aborted_d;

  // Clock chain resets high and CS chain low, so a frame already running
  // across reset never produces a falling-CS event.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sclk_sync <= '1;
      sclk_hist <= 1'b1;
      cs_sync   <= '0;
      cs_hist   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous value of its neighbour.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clock};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_chipselect};
      cs_hist   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_hist;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_hist;

  assign axis.axis_slave_ready = ready_q;
  assign xfer = axis.axis_slave_valid & ready_q;

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // CS rise outranks a coincident clock rise, so the 16th shift can be aborted.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
               else if (sclk_rise && count_q == LAST_BIT) state_d = DONE;
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load       = (state_q == IDLE) && cs_fall;
    do_shift   = (state_q == SHIFT) && !cs_rise && sclk_rise;
    load_value = buf_full_q ? buf_data_q : last_sample_q;
    done_d     = do_shift && (count_q == LAST_BIT);
    underrun_d = load && !buf_full_q;
    aborted_d  = (state_q == SHIFT) && cs_rise;

    shift_d = shift_q;
    count_d = count_q;
    if (load) begin
      shift_d = load_value;
      count_d = '0;
    end else if (do_shift) begin
      shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
      count_d = count_q + 1'b1;
    end

    // A sample accepted while a frame loads stays queued for the next frame.
    buf_full_d    = (buf_full_q && !load) || xfer;
    buf_data_d    = xfer ? axis.axis_slave_data : buf_data_q;
    last_sample_d = load ? load_value : last_sample_q;

    spi_data_d = (state_d == SHIFT) ? shift_d[SAMPLE_WIDTH-1] : 1'b0;
    enable_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      buf_full_q      <= 1'b0;
      buf_data_q      <= '0;
      last_sample_q   <= '0;
      shift_q         <= '0;
      count_q         <= '0;
      ready_q         <= 1'b0;
      spi_data        <= 1'b0;
      spi_data_enable <= 1'b0;
      frame_done      <= 1'b0;
      underrun        <= 1'b0;
      aborted         <= 1'b0;
    end else begin
      buf_full_q      <= buf_full_d;
      buf_data_q      <= buf_data_d;
      last_sample_q   <= last_sample_d;
      shift_q         <= shift_d;
      count_q         <= count_d;
      ready_q         <= !buf_full_d;
      spi_data        <= spi_data_d;
      spi_data_enable <= enable_d;
      frame_done      <= done_d;
      underrun        <= underrun_d;
      aborted         <= aborted_d;
    end
  end

endmodule

// File: tb/tb_spislave.sv
// Self-checking bench for spislave: directed frame table, reset-mid-frame
// sequence, then random frames against a sample-queue reference model.
module tb_spislave;

  localparam int W        = 16;
  localparam int SYNC     = 2;
  localparam int CLK_TRIG = 4;
  localparam int HALF     = CLK_TRIG + 1;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic spi_clock = 1'b1;
  logic spi_chipselect = 1'b1;
  logic spi_data, spi_data_enable, frame_done, underrun, aborted;

  spislave_if #(.SAMPLE_WIDTH(W)) axis ();

  spislave #(.SAMPLE_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clock           (clock),
    .resetn          (resetn),
    .spi_clock       (spi_clock),
    .spi_chipselect  (spi_chipselect),
    .spi_data        (spi_data),
    .spi_data_enable (spi_data_enable),
    .axis            (axis),
    .frame_done      (frame_done),
    .underrun        (underrun),
    .aborted         (aborted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Pulse monitor; cur_edge is the master's count of rising spi_clock edges.
  int cur_edge = 0;
  int done_total = 0, und_total = 0, ab_total = 0, done_edge = 0;
  always @(negedge clock) begin
    if (frame_done) begin
      done_total <= done_total + 1;
      done_edge  <= cur_edge;
    end
    if (underrun) und_total <= und_total + 1;
    if (aborted)  ab_total  <= ab_total + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // Reference model: queue of accepted samples plus the last sample framed.
  logic [W-1:0] model_q[$];
  logic [W-1:0] model_last = '0;

  typedef struct {
    bit          push;
    logic [15:0] data;
    int          edges;
    logic [31:0] cap;
    int          done;
    int          und;
    int          ab;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] d);
    int n;
    n = 0;
    axis.axis_slave_data  = d;
    axis.axis_slave_valid = 1'b1;
    while (!axis.axis_slave_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", {31'b0, axis.axis_slave_ready}, 32'd1);
    tick();
    axis.axis_slave_valid = 1'b0;
    tick();
  endtask

  // Bit n of the capture is what the master sees at its n-th rising edge.
  function automatic logic [31:0] expect_cap(input logic [W-1:0] s, input int n);
    logic [31:0] v;
    v = {16'h0, s};
    if (n >= W) return v << (n - W);
    return v >> (W - n);
  endfunction

  task automatic model_frame(input int n, output logic [31:0] cap, output int und);
    logic [W-1:0] s;
    if (model_q.size() > 0) begin
      s   = model_q.pop_front();
      und = 0;
    end else begin
      s   = model_last;
      und = 1;
    end
    model_last = s;
    cap = expect_cap(s, n);
  endtask

  task automatic run_frame(input int n_edges, input bit chk_ready,
                           output logic [31:0] cap, output int nd, output int nu, output int na);
    int d0, u0, a0;
    d0 = done_total; u0 = und_total; a0 = ab_total;
    cap = '0;
    cur_edge = 0;
    spi_chipselect = 1'b0;
    for (int i = 1; i <= HALF + 3; i++) begin
      tick();
      if (chk_ready && i <= 3) begin
        check("ready_after_cs_fall", {31'b0, axis.axis_slave_ready}, (i == 3) ? 32'd1 : 32'd0);
        check("enable_after_cs_fall", {31'b0, spi_data_enable}, (i == 3) ? 32'd1 : 32'd0);
      end
    end
    for (int k = 1; k <= n_edges; k++) begin
      spi_clock = 1'b0;
      repeat (HALF) tick();
      spi_clock = 1'b1;
      cap = {cap[30:0], spi_data};
      cur_edge = k;
      repeat (HALF) tick();
    end
    spi_chipselect = 1'b1;
    repeat (HALF + 3) tick();
    nd = done_total - d0;
    nu = und_total - u0;
    na = ab_total - a0;
  endtask

  initial begin
    logic [31:0] cap, ecap;
    int nd, nu, na, eund, n;
    logic [W-1:0] d;

    vecs[0] = '{1'b1, 16'hA5C3, 16, 32'h0000A5C3, 1, 0, 0};
    vecs[1] = '{1'b1, 16'h0001, 16, 32'h00000001, 1, 0, 0};
    vecs[2] = '{1'b1, 16'h8000, 16, 32'h00008000, 1, 0, 0};
    vecs[3] = '{1'b1, 16'h1234, 16, 32'h00001234, 1, 0, 0};
    vecs[4] = '{1'b0, 16'h0000, 16, 32'h00001234, 1, 1, 0};
    vecs[5] = '{1'b1, 16'hFFFF,  5, 32'h0000001F, 0, 0, 1};
    vecs[6] = '{1'b0, 16'h0000, 16, 32'h0000FFFF, 1, 1, 0};
    vecs[7] = '{1'b1, 16'hBEEF, 20, 32'h000BEEF0, 1, 0, 0};

    axis.axis_slave_valid = 1'b0;
    axis.axis_slave_data  = '0;

    // Reset state
    repeat (4) tick();
    check("rst_spi_data", {31'b0, spi_data}, 32'd0);
    check("rst_enable", {31'b0, spi_data_enable}, 32'd0);
    check("rst_ready", {31'b0, axis.axis_slave_ready}, 32'd0);
    check("rst_pulses", {29'b0, frame_done, underrun, aborted}, 32'd0);
    resetn = 1'b1;
    tick();
    check("ready_after_reset", {31'b0, axis.axis_slave_ready}, 32'd1);

    // Directed frame table
    foreach (vecs[i]) begin
      if (vecs[i].push) begin
        push(vecs[i].data);
        model_q.push_back(vecs[i].data);
      end
      run_frame(vecs[i].edges, (i == 0), cap, nd, nu, na);
      model_frame(vecs[i].edges, ecap, eund);
      check($sformatf("vec%0d_capture", i), cap, vecs[i].cap);
      check($sformatf("vec%0d_frame_done", i), nd, vecs[i].done);
      check($sformatf("vec%0d_underrun", i), nu, vecs[i].und);
      check($sformatf("vec%0d_aborted", i), na, vecs[i].ab);
      if (vecs[i].done == 1) check($sformatf("vec%0d_done_edge", i), done_edge, 32'd16);
    end

    // Reset pulsed during bit 8 with CS held low
    push(16'h3C3C);
    spi_chipselect = 1'b0;
    repeat (HALF + 3) tick();
    for (int k = 1; k <= 7; k++) begin
      spi_clock = 1'b0;
      repeat (HALF) tick();
      spi_clock = 1'b1;
      repeat (HALF) tick();
    end
    spi_clock = 1'b0;
    repeat (2) tick();
    resetn = 1'b0;
    repeat (3) tick();
    check("midrst_ready_low", {31'b0, axis.axis_slave_ready}, 32'd0);
    resetn = 1'b1;
    tick();
    check("midrst_ready_high", {31'b0, axis.axis_slave_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      spi_clock = 1'b1;
      repeat (HALF) tick();
      check("midrst_spi_data", {31'b0, spi_data}, 32'd0);
      check("midrst_enable", {31'b0, spi_data_enable}, 32'd0);
      spi_clock = 1'b0;
      repeat (HALF) tick();
    end
    spi_clock = 1'b1;
    repeat (HALF) tick();
    spi_chipselect = 1'b1;
    repeat (HALF + 3) tick();
    model_q.delete();
    model_last = '0;
    push(16'h5A5A);
    model_q.push_back(16'h5A5A);
    run_frame(16, 1'b1, cap, nd, nu, na);
    model_frame(16, ecap, eund);
    check("midrst_capture", cap, 32'h00005A5A);
    check("midrst_underrun", nu, 32'd0);
    check("midrst_frame_done", nd, 32'd1);

    // Random frames against the model
    for (int f = 0; f < 30; f++) begin
      if (model_q.size() == 0 && $urandom_range(0, 3) != 0) begin
        d = W'($urandom);
        push(d);
        model_q.push_back(d);
      end
      n = $urandom_range(1, 20);
      model_frame(n, ecap, eund);
      run_frame(n, 1'b0, cap, nd, nu, na);
      check($sformatf("rnd%0d_capture_n%0d", f, n), cap, ecap);
      check($sformatf("rnd%0d_underrun", f), nu, eund);
      check($sformatf("rnd%0d_frame_done", f), nd, (n >= W) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_aborted", f), na, (n < W) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spislave.md
Name: spislave

Overview:
- SPI slave transmitter (MISO-only), synchronous to the system clock.
- Accepts samples on an AXI-Stream slave interface and serialises one sample MSB-first per chip-select frame onto spi_data.
- Mode: clock idles high, data is sampled by the master on the rising spi_clock.
- Serves as the synthesizable bench/loopback partner for the team's SPI master acquisition block, and as a sensor emulator on the DE0-Nano.

Parameters:
- SAMPLE_WIDTH, 16: bits per frame; also the AXIS data width.
- SYNC_STAGES, 2: synchroniser depth on spi_clock and spi_chipselect; minimum 2.

Ports:
- clock  in  1  system clock; every flop is on posedge clock.
- resetn  in  1  synchronous active-low reset.
- spi_clock  in  1  SPI clock from the master; idles high.
- spi_chipselect  in  1  active-low frame select from the master.
- spi_data  out  1  serial data to the master (registered).
- spi_data_enable  out  1  high while selected; used as the pad output-enable.
- axis_slave_valid  in  1  sample valid.
- axis_slave_ready  out  1  high while the holding buffer is empty.
- axis_slave_data  in  SAMPLE_WIDTH  sample to send.
- frame_done  out  1  one-cycle pulse when a full frame has been shifted.
- underrun  out  1  one-cycle pulse when a frame starts with the buffer empty.
- aborted  out  1  one-cycle pulse when CS deasserts before SAMPLE_WIDTH bits.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - Outputs: spi_data=0, spi_data_enable=0, axis_slave_ready=0, all pulses 0.
  - Internal state: buffer empty, last_sample=0, bit count 0, state IDLE.
  - Synchronisers: spi_clock chain and its edge-history flop reset to 1; spi_chipselect chain and its history flop reset to 0.
  - Consequence: a frame already in progress across reset produces no falling-CS detection. The block stays idle until CS is seen high, then low.
  - axis_slave_ready becomes 1 on the first cycle after reset is released.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - Pin-to-spi_data latency is SYNC_STAGES+1 clocks.
  - Legal operation requires every spi_clock half-period to be at least SYNC_STAGES+3 system clocks. With a master toggling every CLK_TRIG+1 clocks, this means CLK_TRIG >= SYNC_STAGES+2.
- Holding buffer (one entry):
  - axis_slave_ready = ~buf_full.
  - A transfer (valid & ready) sets buf_full and captures the data.
  - Data is held until a frame loads it; ready is 0 while full.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on CS fall:
    - If buf_full: shift register <= buffer, last_sample <= buffer, clear buf_full.
    - Otherwise: shift register <= last_sample and pulse underrun.
    - A sample accepted in that same cycle stays in the buffer for the next frame.
    - Set spi_data_enable=1, bit count=0, go to SHIFT.
    - spi_data presents the MSB on the next clock.
  - SHIFT, on spi_clock rise (after the master has sampled):
    - Increment bit count and shift left, filling with 0.
    - When the count reaches SAMPLE_WIDTH: pulse frame_done, go to DONE.
  - DONE: spi_data=0 and further spi_clock edges are ignored.
  - CS rise from SHIFT: pulse aborted, return to IDLE. The partial sample is not re-sent; last_sample keeps it.
  - CS rise from DONE: return to IDLE.
  - Any CS rise: spi_data_enable=0, spi_data=0.
- Simultaneous events:
  - If CS rise and spi_clock rise are detected in the same cycle, CS rise wins and no shift occurs.
  - In SHIFT, frame_done takes priority over aborted only if the count has already reached SAMPLE_WIDTH.
  - spi_clock edges seen in IDLE are ignored.

Test Plan:
- Bench master (CLK_TRIG=4, 16 rising edges per frame). Push 0xA5C3, then run one frame:
  - Master captures 0xA5C3.
  - frame_done pulses once.
  - axis_slave_ready returns to 1 the cycle after CS fall is detected.
- Back-to-back: push 0x0001 and 0x8000 with one frame between pushes:
  - Captures are 0x0001 then 0x8000.
  - No underrun.
- Underrun: after sending 0x1234, run a frame with no push:
  - Capture is 0x1234.
  - underrun pulses exactly once.
- Abort: push 0xFFFF, deassert CS after 5 rising edges:
  - aborted pulses and the master holds 0x001F.
  - The next frame with no push repeats 0xFFFF and pulses underrun.
- Reset mid-frame: pulse resetn low during bit 8 with CS held low:
  - spi_data=0 and spi_data_enable=0 until CS goes high.
  - The following frame with a pushed 0x5A5A captures 0x5A5A.
- Extra clocks: 20 rising edges in one frame with 0xBEEF:
  - The first 16 bits are 0xBEEF and bits 17–20 are 0.
  - frame_done pulses at edge 16 only.
